// File: rtl/transfer_pkg.sv
// Shared definitions for both ends of the transfer link: command bytes,
// scanner control codes and the scheduler FSM state.
package transfer_pkg;

  localparam logic [7:0] CMD_FILL  = 8'd0;
  localparam logic [7:0] CMD_BUF50 = 8'd1;
  localparam logic [7:0] CMD_BUF80 = 8'd2;
  localparam logic [7:0] CMD_BUF90 = 8'd3;
  localparam logic [7:0] CMD_FULL  = 8'd4;
  localparam logic [7:0] CMD_FLUSH = 8'd5;
  localparam logic [7:0] CMD_READY = 8'd6;
  localparam logic [7:0] CMD_BIN   = 8'd7;
  localparam logic [7:0] CMD_ASCII = 8'd8;

  localparam logic [1:0] SCAN_HOLD  = 2'b00;
  localparam logic [1:0] SCAN_START = 2'b01;
  localparam logic [1:0] SCAN_STOP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STATUS,
    ST_HDR,
    ST_DATA
  } state_t;

  // Occupancy band 1..4 maps onto the matching buffer-status command.
  function automatic logic [7:0] status_cmd(input logic [2:0] band);
    case (band)
      3'd1:    return CMD_BUF50;
      3'd2:    return CMD_BUF80;
      3'd3:    return CMD_BUF90;
      3'd4:    return CMD_FULL;
      default: return CMD_FILL;
    endcase
  endfunction

endpackage

// File: rtl/transfer_scheduler_byte_serializer.sv
// Free-running 8-cycle slot timer with an MSB-first shift register; one byte
// is loaded at the last cycle of each slot and shifted out over the next slot.
module byte_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_byte,
  output logic       slot_end,
  output logic [2:0] bit_cnt,
  output logic       data_out
);

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       data_out_q, data_out_d;

  assign slot_end = (bit_cnt_q == 3'd7);
  assign bit_cnt  = bit_cnt_q;
  assign data_out = data_out_q;

  // Bit 7 goes straight to the output flop, the rest queue up behind it.
  always_comb begin
    bit_cnt_d = bit_cnt_q + 3'd1;
    if (slot_end && load) begin
      shift_d    = {load_byte[6:0], 1'b0};
      data_out_d = load_byte[7];
    end else begin
      shift_d    = {shift_q[6:0], 1'b0};
      data_out_d = shift_q[7];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      data_out_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: rtl/transfer_scheduler.sv
// Transmit-side link controller: buffer-status commands on rising occupancy
// bands, header + fixed-length data bursts when the peer is ready, scanner control.
module transfer_scheduler
  import transfer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int BURST = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] bufLevel,
  input  logic [7:0]    bufData,
  output logic          bufRd,
  input  logic          asciiMode,
  input  logic          readyForTransferIn,
  output logic          dataOut,
  output logic [1:0]    localScannerOut,
  output logic          busy,
  output state_t        dbg_state
);

  localparam int T50 = (DEPTH * 5) / 10;
  localparam int T80 = (DEPTH * 8) / 10;
  localparam int T90 = (DEPTH * 9) / 10;
  localparam int RW  = $clog2(BURST + 1);

  state_t        state_q, state_d;
  logic [RW-1:0] remaining_q, remaining_d;
  logic [2:0]    last_band_q, last_band_d;
  logic          status_pending_q, status_pending_d;
  logic          buf_rd_q, buf_rd_d;
  logic          busy_q, busy_d;
  logic [1:0]    scan_q, scan_d;

  logic [2:0] band;
  logic       rise;
  logic       decide;
  logic       slot_end;
  logic [2:0] bit_cnt;
  logic [7:0] load_byte;

  always_comb begin
    band = 3'd0;
    if (bufLevel == LW'(DEPTH))     band = 3'd4;
    else if (bufLevel >= LW'(T90))  band = 3'd3;
    else if (bufLevel >= LW'(T80))  band = 3'd2;
    else if (bufLevel >= LW'(T50))  band = 3'd1;
  end

  assign rise   = (band > last_band_q);
  assign decide = slot_end && ((state_q == ST_IDLE) || (state_q == ST_STATUS) ||
                               ((state_q == ST_DATA) && (remaining_q == '0)));

  // A rise seen in the boundary cycle itself is served in the same decision.
  always_comb begin
    state_d          = state_q;
    remaining_d      = remaining_q;
    load_byte        = CMD_FILL;
    last_band_d      = band;
    status_pending_d = status_pending_q | rise;
    if (decide) begin
      if (status_pending_q || rise) begin
        load_byte        = status_cmd(band);
        status_pending_d = 1'b0;
        state_d          = ST_STATUS;
      end else if (readyForTransferIn && (bufLevel >= LW'(BURST))) begin
        load_byte = asciiMode ? CMD_ASCII : CMD_BIN;
        state_d   = ST_HDR;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (slot_end && (state_q == ST_HDR)) begin
      load_byte   = bufData;
      remaining_d = RW'(BURST - 1);
      state_d     = ST_DATA;
    end else if (slot_end && (state_q == ST_DATA)) begin
      load_byte   = bufData;
      remaining_d = remaining_q - RW'(1);
    end
  end

  // Pop strobe: bufRd is high for the whole last cycle of a slot whose end
  // loads bufData; the FIFO advances on that same edge. It is set one cycle
  // early so that it can come straight from a flop.
  always_comb begin
    buf_rd_d = (bit_cnt == 3'd6) &&
               ((state_q == ST_HDR) || ((state_q == ST_DATA) && (remaining_q != '0)));
    busy_d   = slot_end ? ((state_d == ST_HDR) || (state_d == ST_DATA)) : busy_q;
    scan_d   = SCAN_HOLD;
    if (band == 3'd4)      scan_d = SCAN_STOP;
    else if (band == 3'd0) scan_d = SCAN_START;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      remaining_q      <= '0;
      last_band_q      <= 3'd0;
      status_pending_q <= 1'b0;
      buf_rd_q         <= 1'b0;
      busy_q           <= 1'b0;
      scan_q           <= SCAN_HOLD;
    end else begin
      state_q          <= state_d;
      remaining_q      <= remaining_d;
      last_band_q      <= last_band_d;
      status_pending_q <= status_pending_d;
      buf_rd_q         <= buf_rd_d;
      busy_q           <= busy_d;
      scan_q           <= scan_d;
    end
  end

  byte_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_end),
    .load_byte (load_byte),
    .slot_end  (slot_end),
    .bit_cnt   (bit_cnt),
    .data_out  (dataOut)
  );

  assign bufRd           = buf_rd_q;
  assign busy            = busy_q;
  assign localScannerOut = scan_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_transfer_scheduler.sv
// Bench for transfer_scheduler: slot-level model of the link predicts every
// byte on the serial line plus the per-cycle pop, busy and scanner outputs.
module tb_transfer_scheduler;
  import transfer_pkg::*;

  localparam int DEPTH = 16;
  localparam int BURST = 4;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int T50   = (DEPTH * 5) / 10;
  localparam int T80   = (DEPTH * 8) / 10;
  localparam int T90   = (DEPTH * 9) / 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [LW-1:0] bufLevel = '0;
  logic [7:0]    bufData = 8'd0;
  logic          bufRd;
  logic          asciiMode = 1'b0;
  logic          readyForTransferIn = 1'b0;
  logic          dataOut;
  logic [1:0]    localScannerOut;
  logic          busy;
  state_t        dbg_state;

  transfer_scheduler #(.DEPTH(DEPTH), .BURST(BURST), .LW(LW)) dut (
    .clk                (clk),
    .rst                (rst),
    .bufLevel           (bufLevel),
    .bufData            (bufData),
    .bufRd              (bufRd),
    .asciiMode          (asciiMode),
    .readyForTransferIn (readyForTransferIn),
    .dataOut            (dataOut),
    .localScannerOut    (localScannerOut),
    .busy               (busy),
    .dbg_state          (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] buf_q[$];
  logic [7:0] exp_q[$];
  logic       pop_req = 1'b0;

  // reference model state
  int         m_last = 0;
  bit         m_pending = 0;
  int         burst_left = 0;
  bit         slot_busy = 0;
  logic [1:0] exp_scan = 2'b00;
  int         tb_bit = 0;
  logic [7:0] rx = 8'd0;

  function automatic int band_of(input int lvl);
    if (lvl >= DEPTH) return 4;
    if (lvl >= T90)   return 3;
    if (lvl >= T80)   return 2;
    if (lvl >= T50)   return 1;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_buf();
    bufLevel = LW'(buf_q.size());
    bufData  = (buf_q.size() > 0) ? buf_q[0] : 8'd0;
  endtask

  task automatic step(input int push_pct);
    @(posedge clk);
    #1;
    if (pop_req) begin
      if (buf_q.size() > 0) void'(buf_q.pop_front());
      pop_req = 1'b0;
    end
    if (buf_q.size() < DEPTH && int'($urandom_range(99)) < push_pct)
      buf_q.push_back(8'($urandom));
    drive_buf();
  endtask

  task automatic fill_to(input int n);
    while (buf_q.size() < n && buf_q.size() < DEPTH) buf_q.push_back(8'($urandom));
    drive_buf();
  endtask

  task automatic run(input int n, input int push_pct, input int ready_pct);
    for (int i = 0; i < n; i++) begin
      step(push_pct);
      if (int'($urandom_range(99)) < 10) readyForTransferIn = (int'($urandom_range(99)) < ready_pct);
      if (int'($urandom_range(99)) < 5)  asciiMode = $urandom_range(1);
    end
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 200) begin
      step(0);
      n++;
    end
    check(name, busy, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dataOut"}, dataOut, 0);
    check({tag, "_bufRd"}, bufRd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_scan"}, localScannerOut, 2'b00);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin : mon
    int lvl;
    int band;
    if (!rst) begin
      exp_q.delete();
      exp_q.push_back(CMD_FILL);
      m_last     = 0;
      m_pending  = 0;
      burst_left = 0;
      slot_busy  = 0;
      exp_scan   = 2'b00;
      tb_bit     = 0;
      rx         = 8'd0;
      pop_req    = 1'b0;
    end else begin
      lvl  = int'(bufLevel);
      band = band_of(lvl);
      rx   = {rx[6:0], dataOut};
      check("busy", busy, slot_busy);
      check("scanner", localScannerOut, exp_scan);
      check("bufRd", bufRd, (tb_bit == 7 && burst_left > 0));
      if (bufRd) pop_req = 1'b1;
      exp_scan = (band == 4) ? 2'b10 : (band == 0) ? 2'b01 : 2'b00;
      if (band > m_last) m_pending = 1;
      m_last = band;
      if (tb_bit == 7) begin
        if (exp_q.size() == 0) begin
          check("byte_queue_empty", rx, 32'hFFFF_FFFF);
        end else begin
          check("line_byte", rx, exp_q.pop_front());
        end
        if (burst_left > 0) begin
          check("level_ge_remaining", (lvl >= burst_left), 1);
          burst_left--;
          slot_busy = 1;
        end else if (m_pending) begin
          exp_q.push_back(8'(m_last));
          m_pending = 0;
          slot_busy = 0;
        end else if (readyForTransferIn && lvl >= BURST) begin
          exp_q.push_back(asciiMode ? CMD_ASCII : CMD_BIN);
          for (int i = 0; i < BURST; i++) exp_q.push_back(buf_q[i]);
          burst_left = BURST;
          slot_busy  = 1;
        end else begin
          exp_q.push_back(CMD_FILL);
          slot_busy = 0;
        end
      end
      tb_bit = (tb_bit + 1) % 8;
    end
  end

  initial begin
    drive_buf();
    #2;
    check_reset_outputs("por");
    repeat (2) step(0);
    rst = 1'b1;

    // idle with empty buffer, peer not ready
    repeat (24) step(0);

    // threshold crossings: 7 -> 8 -> hold -> 14 -> 16
    fill_to(7);  repeat (16) step(0);
    fill_to(8);  repeat (32) step(0);
    fill_to(14); repeat (24) step(0);
    fill_to(16); repeat (24) step(0);

    // binary bursts drain the buffer
    readyForTransferIn = 1'b1;
    asciiMode          = 1'b0;
    repeat (200) step(0);

    // ready drops mid-burst, status crossing during a burst
    readyForTransferIn = 1'b0;
    fill_to(6);
    repeat (16) step(0);
    readyForTransferIn = 1'b1;
    wait_busy("wait_burst1");
    repeat (12) step(0);
    readyForTransferIn = 1'b0;
    fill_to(DEPTH - 2);
    repeat (48) step(0);
    asciiMode          = 1'b1;
    readyForTransferIn = 1'b1;
    repeat (64) step(0);

    // randomized traffic
    run(800, 40, 60);

    // reset mid-burst
    readyForTransferIn = 1'b1;
    fill_to(DEPTH);
    wait_busy("wait_burst2");
    repeat (11) step(0);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) step(0);
    rst = 1'b1;

    run(800, 35, 70);
    readyForTransferIn = 1'b0;
    repeat (48) step(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
